rgb_fade_ctrl: RTL and testbench
================================

RGB_FADE_CTRL -- requirements
Module: rgb_fade_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- LEVEL_W, 8, width of each channel level.
- TICK_DIV, 256, clk cycles per fade step; legal range 2..65535.
- STEP, 1, maximum level change per channel per tick.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- man_level0/1/2, in, LEVEL_W, manual levels from the encoders.
- mode_auto, in, 1, 1 = auto fade mode, 0 = manual passthrough.
- tgt_valid, in, 1, target colour offered.
- tgt_level0/1/2, in, LEVEL_W, target colour, valid while tgt_valid is high.
- tgt_ready, out, 1, target accepted when tgt_valid & tgt_ready.
- level0/1/2, out, LEVEL_W, registered levels driving the PWM channels.
- busy, out, 1, high in states FADE and DONE.
- done, out, 1, one-cycle pulse when a fade completes.

Function
REQ-003 The FSM SHALL have the states IDLE, FADE and DONE.
REQ-004 In IDLE with mode_auto=0, level0/1/2 SHALL equal man_level0/1/2 sampled on the previous edge (1-cycle latency).
REQ-005 In IDLE with mode_auto=1, level0/1/2 SHALL hold their current values.
REQ-006 tgt_ready SHALL equal (state==IDLE) & mode_auto, decoded combinationally from registered state.
REQ-007 On tgt_valid & tgt_ready, the block SHALL capture the three targets, clear the tick counter and enter FADE on the next edge.
REQ-008 In FADE, a tick SHALL occur when the tick counter reaches TICK_DIV-1; the counter then wraps to 0.
REQ-009 On each tick, each channel SHALL move toward its target by min(STEP, |target-level|), computed in LEVEL_W+1 bits; the level SHALL never overshoot and never wrap past 0 or 2^LEVEL_W-1.
REQ-010 Every FADE cycle, if all three levels equal their targets, the FSM SHALL enter DONE on the next edge. A target equal to the current levels therefore reaches DONE 2 cycles after acceptance.
REQ-011 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-012 If mode_auto falls during FADE or DONE, the FSM SHALL go to IDLE on the next edge with no done pulse; manual tracking per REQ-004 then resumes.
REQ-013 tgt_valid SHALL be ignored whenever tgt_ready=0. A held tgt_valid SHALL be re-accepted in the first IDLE cycle.

Reset
REQ-014 While reset is high: state=IDLE, level0/1/2=0, targets=0, tick counter=0, done=0, busy=0. tgt_ready follows REQ-006.
REQ-015 Reset asserted mid-fade SHALL abort the fade immediately, with no done pulse.

Configuration
REQ-016 Macro RGB_FADE_BREATHE_EN SHALL add the input port breathe (1 bit).
- With the macro defined and breathe=1 at DONE: the block SHALL pulse done, capture the levels held at the start of the completed fade as the new targets, and re-enter FADE instead of IDLE. This ping-pongs until breathe=0 or mode_auto=0.
- Without the macro: the port SHALL be absent and DONE always returns to IDLE.

Structure
REQ-017 Package rgb_pkg SHALL hold the LEVEL_W default and the FSM state enum typedef.
REQ-018 The tick counter SHALL be the sub-module fade_tick (inputs clk, reset, clr, en; output tick).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Manual mode: mode_auto=0, man_level0=0x5A -> level0=0x5A one cycle later; tgt_ready=0.
- Basic fade: TICK_DIV=4, STEP=1, levels 0, target (3,0,2) -> level0 reaches 3 after 3 ticks; done pulses once; busy high from acceptance+1 to DONE.
- No wrap: STEP=16, level 0xF8, target 0xFF -> next tick gives 0xFF, never 0x08; target 0x00 from 0x05 -> 0x00.
- Equal target: target equals current levels -> done exactly 2 cycles after acceptance.
- Abort: mode_auto=0 mid-fade -> IDLE next cycle; no done; levels track manual inputs.
- Reset mid-fade: reset asserted asynchronously -> levels 0 without waiting for a clk edge; done stays 0. With RGB_FADE_BREATHE_EN and breathe=1, a 0->8 fade returns to 0 with two done pulses.

Source files
------------

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared defaults and FSM state type for the RGB fade controller
package rgb_pkg;
  localparam int LEVEL_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, FADE, DONE} state_t;
endpackage

// File: rtl/fade_tick.sv
// fade_tick: free-running divider that pulses tick every TICK_DIV enabled cycles
module fade_tick #(
  parameter int TICK_DIV = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = en & (cnt == CW'(TICK_DIV - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: three-channel level controller with manual passthrough and timed auto fade
// RGB_FADE_BREATHE_EN adds the breathe input, which ping-pongs completed fades back to their start
module rgb_fade_ctrl
  import rgb_pkg::*;
#(
  parameter int LEVEL_W  = LEVEL_W_DEF,
  parameter int TICK_DIV = 256,
  parameter int STEP     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] man_level0,
  input  logic [LEVEL_W-1:0] man_level1,
  input  logic [LEVEL_W-1:0] man_level2,
  input  logic               mode_auto,
  input  logic               tgt_valid,
  input  logic [LEVEL_W-1:0] tgt_level0,
  input  logic [LEVEL_W-1:0] tgt_level1,
  input  logic [LEVEL_W-1:0] tgt_level2,
  output logic               tgt_ready,
  output logic [LEVEL_W-1:0] level0,
  output logic [LEVEL_W-1:0] level1,
  output logic [LEVEL_W-1:0] level2,
  output logic               busy,
`ifdef RGB_FADE_BREATHE_EN
  input  logic               breathe,
`endif
  output logic               done
);
  localparam logic [LEVEL_W:0] STEP_X = (LEVEL_W + 1)'(STEP);
  state_t state;
  logic [2:0][LEVEL_W-1:0] lvl, tgt, org, man, tin, nxt;
  logic accept, rearm, tick, match, again;
`ifdef RGB_FADE_BREATHE_EN
  assign again = breathe;
`else
  assign again = 1'b0;
`endif
  assign man = {man_level2, man_level1, man_level0};
  assign tin = {tgt_level2, tgt_level1, tgt_level0};
  assign {level2, level1, level0} = lvl;
  assign tgt_ready = (state == IDLE) & mode_auto;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign accept = tgt_valid & tgt_ready;
  assign rearm = (state == DONE) & mode_auto & again;
  assign match = lvl == tgt;
  // Distance is taken one bit wider so the clamp never overshoots or wraps.
  function automatic logic [LEVEL_W-1:0] toward(input logic [LEVEL_W-1:0] l, input logic [LEVEL_W-1:0] t);
    logic [LEVEL_W:0] d;
    d = (t > l) ? {1'b0, t} - {1'b0, l} : {1'b0, l} - {1'b0, t};
    d = (d > STEP_X) ? STEP_X : d;
    return (t > l) ? LEVEL_W'({1'b0, l} + d) : LEVEL_W'({1'b0, l} - d);
  endfunction
  always_comb begin
    nxt = lvl;
    for (int i = 0; i < 3; i++)
      nxt[i] = (state == IDLE && !mode_auto) ? man[i] :
               (state == FADE && mode_auto && tick) ? toward(lvl[i], tgt[i]) : lvl[i];
  end
  fade_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clr(accept | rearm),
    .en(state == FADE),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lvl <= '0;
      tgt <= '0;
      org <= '0;
    end else begin
      state <= !mode_auto ? IDLE : (accept || rearm) ? FADE : (state == FADE) ? (match ? DONE : FADE) : IDLE;
      lvl <= nxt;
      if (accept) begin
        tgt <= tin;
        org <= lvl;
      end
      if (rearm) begin
        tgt <= org;
        org <= lvl;
      end
    end
endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb_rgb_fade_ctrl: directed checks of manual, fade, clamp, abort and reset behaviour
module tb_rgb_fade_ctrl;
  logic clk = 0, reset = 1, mode_auto = 0, tgt_valid = 0;
  logic [7:0] man0 = 0, man1 = 0, man2 = 0, t0 = 0, t1 = 0, t2 = 0;
  logic [7:0] a0, a1, a2, b0, b1, b2;
  logic ra, rb, ba, bb, da, db;
`ifdef RGB_FADE_BREATHE_EN
  logic breathe = 0;
`endif
  int vecs = 0, miscompares = 0, npa = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (da) npa++;

  rgb_fade_ctrl #(.LEVEL_W(8), .TICK_DIV(4), .STEP(1)) u_a (
    .clk(clk), .reset(reset),
    .man_level0(man0), .man_level1(man1), .man_level2(man2),
    .mode_auto(mode_auto), .tgt_valid(tgt_valid),
    .tgt_level0(t0), .tgt_level1(t1), .tgt_level2(t2),
    .tgt_ready(ra), .level0(a0), .level1(a1), .level2(a2),
    .busy(ba),
`ifdef RGB_FADE_BREATHE_EN
    .breathe(breathe),
`endif
    .done(da)
  );

  rgb_fade_ctrl #(.LEVEL_W(8), .TICK_DIV(2), .STEP(16)) u_b (
    .clk(clk), .reset(reset),
    .man_level0(man0), .man_level1(man1), .man_level2(man2),
    .mode_auto(mode_auto), .tgt_valid(tgt_valid),
    .tgt_level0(t0), .tgt_level1(t1), .tgt_level2(t2),
    .tgt_ready(rb), .level0(b0), .level1(b1), .level2(b2),
    .busy(bb),
`ifdef RGB_FADE_BREATHE_EN
    .breathe(breathe),
`endif
    .done(db)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    t0 = x; t1 = y; t2 = z; tgt_valid = 1;
  endtask

  initial begin
    cyc(1);
    check("rst_level0", a0, 8'h00);
    check("rst_busy", ba, 0);
    check("rst_done", da, 0);
    check("rst_ready", ra, 0);
    reset = 0;
    man0 = 8'h5A; man1 = 8'h11; man2 = 8'h22;
    cyc(1);
    check("man_level0", a0, 8'h5A);
    check("man_level1", a1, 8'h11);
    check("man_ready", ra, 0);
    man0 = 0; man1 = 0; man2 = 0;
    cyc(1);
    check("man_zero", a0, 8'h00);
    mode_auto = 1;
    #1 check("auto_ready", ra, 1);
    offer(3, 0, 2);
    cyc(1);
    tgt_valid = 0;
    check("fade_busy", ba, 1);
    check("fade_ready", ra, 0);
    check("fade_l0_n1", a0, 0);
    cyc(3);
    check("fade_l0_n4", a0, 0);
    cyc(1);
    check("fade_l0_n5", a0, 1);
    check("fade_l2_n5", a2, 1);
    cyc(4);
    check("fade_l0_n9", a0, 2);
    check("fade_l1_n9", a1, 0);
    check("fade_l2_n9", a2, 2);
    cyc(4);
    check("fade_l0_n13", a0, 3);
    check("fade_l2_n13", a2, 2);
    check("fade_done_n13", da, 0);
    check("fade_busy_n13", ba, 1);
    cyc(1);
    check("fade_done_n14", da, 1);
    check("fade_busy_n14", ba, 1);
    cyc(1);
    check("fade_done_n15", da, 0);
    check("fade_busy_n15", ba, 0);
    check("fade_ready_n15", ra, 1);
    check("fade_hold", a0, 3);
    offer(3, 0, 2);
    cyc(1);
    tgt_valid = 0;
    check("eq_done_n1", da, 0);
    check("eq_busy_n1", ba, 1);
    cyc(1);
    check("eq_done_n2", da, 1);
    cyc(1);
    check("eq_done_n3", da, 0);
    check("eq_busy_n3", ba, 0);
    offer(9, 9, 9);
    cyc(1);
    tgt_valid = 0;
    cyc(4);
    check("ab_l0_n5", a0, 4);
    cyc(1);
    mode_auto = 0;
    man0 = 8'h40; man1 = 8'h41; man2 = 8'h42;
    cyc(1);
    check("ab_busy", ba, 0);
    check("ab_done", da, 0);
    check("ab_hold", a0, 4);
    cyc(1);
    check("ab_track0", a0, 8'h40);
    check("ab_track2", a2, 8'h42);
    check("ab_npulse", npa, 2);
    man0 = 8'hF8; man1 = 8'h05; man2 = 8'h80;
    cyc(1);
    check("nw_start", b0, 8'hF8);
    mode_auto = 1;
    offer(8'hFF, 8'h00, 8'h80);
    cyc(1);
    tgt_valid = 0;
    cyc(1);
    check("nw_l0_n2", b0, 8'hF8);
    check("nw_l1_n2", b1, 8'h05);
    check("nw_ready_n2", rb, 0);
    cyc(1);
    check("nw_l0_top", b0, 8'hFF);
    check("nw_l1_zero", b1, 8'h00);
    check("nw_l2_hold", b2, 8'h80);
    check("nw_busy", bb, 1);
    cyc(1);
    check("nw_done", db, 1);
    mode_auto = 0;
    cyc(1);
    check("nw_a_abort", da, 0);
    check("nw_b_idle", db, 0);
    man0 = 0; man1 = 0; man2 = 0;
    cyc(1);
    mode_auto = 1;
    offer(8'h20, 8'h20, 8'h20);
    cyc(1);
    tgt_valid = 0;
    cyc(8);
    check("rm_l0_n9", a0, 2);
    #2 reset = 1;
    #1;
    check("rm_level0", a0, 0);
    check("rm_level1", a1, 0);
    check("rm_busy", ba, 0);
    check("rm_done", da, 0);
    check("rm_ready", ra, 1);
    check("rm_npulse", npa, 2);
    @(negedge clk);
    reset = 0;
`ifdef RGB_FADE_BREATHE_EN
    breathe = 1;
    offer(8, 8, 8);
    cyc(1);
    tgt_valid = 0;
    cyc(32);
    check("br_up", a0, 8);
    check("br_up_done", da, 0);
    cyc(1);
    check("br_done1", da, 1);
    cyc(1);
    check("br_refade_done", da, 0);
    check("br_refade_busy", ba, 1);
    cyc(32);
    check("br_down", a0, 0);
    cyc(1);
    check("br_done2", da, 1);
    breathe = 0;
    cyc(1);
    check("br_idle", ba, 0);
    check("br_final", a0, 0);
    check("br_npulse", npa, 4);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
